// File: rtl/dds_cfg_pkg.sv
// Shared constants for the DDS configuration controller: opcodes, register
// select codes, error codes, FSM encoding and the captured command frame.
package dds_cfg_pkg;

  localparam logic [7:0] OP_FREQ  = 8'h01;
  localparam logic [7:0] OP_PHASE = 8'h02;
  localparam logic [7:0] OP_AMP   = 8'h03;
  localparam logic [7:0] OP_WAVE  = 8'h04;
  localparam logic [7:0] OP_RUN   = 8'h05;

  localparam logic [2:0] ADDR_FREQ  = 3'd0;
  localparam logic [2:0] ADDR_PHASE = 3'd1;
  localparam logic [2:0] ADDR_AMP   = 3'd2;
  localparam logic [2:0] ADDR_WAVE  = 3'd3;
  localparam logic [2:0] ADDR_RUN   = 3'd4;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BAD_OP  = 2'd1;
  localparam logic [1:0] ERR_OVERRUN = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_WRITE  = 2'd2,
    ST_UPDATE = 2'd3
  } state_t;

  typedef struct packed {
    logic [7:0]  a;
    logic [15:0] b;
    logic [15:0] c;
    logic [7:0]  d;
  } cmd_t;

endpackage

// File: rtl/dds_cfg_timeout.sv
// WRITE-phase watchdog: counts up from 0 while enabled and flags the cycle
// on which the count reaches TIMEOUT_CYC-1.
module dds_cfg_timeout #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] r_cnt;

  assign o_expired = i_en && (r_cnt == LAST);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en && !o_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dds_cfg_ctrl.sv
// Decodes received command frames into DDS register writes with a
// valid/ready handshake, write timeout, overrun detection and a command count.
//
// state     | meaning
// ST_IDLE   | waiting for recv_done; captures the frame
// ST_DECODE | one cycle: validate opcode/channel, load cfg_* outputs
// ST_WRITE  | cfg_valid high until cfg_ready or timeout
// ST_UPDATE | one cycle: dds_update pulse, count command, clear error
module dds_cfg_ctrl
  import dds_cfg_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024,
  parameter int NUM_CH      = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        recv_done,
  input  logic [7:0]  dataA,
  input  logic [15:0] dataB,
  input  logic [15:0] dataC,
  input  logic [7:0]  dataD,
  output logic        cfg_valid,
  input  logic        cfg_ready,
  output logic [1:0]  cfg_ch,
  output logic [2:0]  cfg_addr,
  output logic [31:0] cfg_data,
  output logic        dds_update,
  output logic        busy,
  output logic [1:0]  err_code,
  output logic [7:0]  cmd_cnt
);

  state_t      r_state, w_state_nx;
  cmd_t        r_cmd;
  logic [1:0]  r_cfg_ch;
  logic [2:0]  r_cfg_addr;
  logic [31:0] r_cfg_data;
  logic [1:0]  r_err;
  logic [7:0]  r_cmd_cnt;

  logic        w_op_ok, w_ch_ok, w_cmd_ok, w_expired;
  logic [1:0]  w_ch;
  logic [2:0]  w_addr;
  logic [31:0] w_data;
  logic        w_unused;

  assign cfg_valid  = (r_state == ST_WRITE);
  assign dds_update = (r_state == ST_UPDATE);
  assign busy       = (r_state != ST_IDLE);
  assign cfg_ch     = r_cfg_ch;
  assign cfg_addr   = r_cfg_addr;
  assign cfg_data   = r_cfg_data;
  assign err_code   = r_err;
  assign cmd_cnt    = r_cmd_cnt;
  assign w_unused   = ^r_cmd.d[3:2];

  dds_cfg_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .sys_clk   (sys_clk),
    .rst       (sys_rst_n),
    .i_clear   (r_state != ST_WRITE),
    .i_en      (r_state == ST_WRITE),
    .o_expired (w_expired)
  );

  always_comb begin
    w_op_ok = 1'b1;
    w_ch    = r_cmd.d[1:0];
    w_addr  = ADDR_FREQ;
    w_data  = '0;
    case (r_cmd.a)
      OP_FREQ:  begin w_addr = ADDR_FREQ;  w_data = {r_cmd.c, r_cmd.b}; end
      OP_PHASE: begin w_addr = ADDR_PHASE; w_data = {20'b0, r_cmd.b[11:0]}; end
      OP_AMP:   begin w_addr = ADDR_AMP;   w_data = {22'b0, r_cmd.b[9:0]}; end
      OP_WAVE:  begin w_addr = ADDR_WAVE;  w_data = {28'b0, r_cmd.d[7:4]}; end
      OP_RUN:   begin w_addr = ADDR_RUN;   w_data = {28'b0, r_cmd.b[3:0]}; w_ch = 2'd0; end
      default:  w_op_ok = 1'b0;
    endcase
    // RUN is a global register, so its channel field is not range-checked
    w_ch_ok  = (r_cmd.a == OP_RUN) || ({30'd0, r_cmd.d[1:0]} < NUM_CH);
    w_cmd_ok = w_op_ok && w_ch_ok;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE:   if (recv_done) w_state_nx = ST_DECODE;
      ST_DECODE: w_state_nx = w_cmd_ok ? ST_WRITE : ST_IDLE;
      ST_WRITE: begin
        if (cfg_ready)      w_state_nx = ST_UPDATE;
        else if (w_expired) w_state_nx = ST_IDLE;
      end
      ST_UPDATE: w_state_nx = ST_IDLE;
      default:   w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) r_state <= ST_IDLE;
    else           r_state <= w_state_nx;
  end

  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      r_cmd      <= '0;
      r_cfg_ch   <= '0;
      r_cfg_addr <= '0;
      r_cfg_data <= '0;
      r_err      <= ERR_NONE;
      r_cmd_cnt  <= '0;
    end else begin
      if ((r_state == ST_IDLE) && recv_done) r_cmd <= {dataA, dataB, dataC, dataD};
      if ((r_state == ST_DECODE) && w_cmd_ok) begin
        r_cfg_ch   <= w_ch;
        r_cfg_addr <= w_addr;
        r_cfg_data <= w_data;
      end
      if (r_state == ST_UPDATE) r_cmd_cnt <= r_cmd_cnt + 8'd1;
      // a dropped frame is reported even in the cycle UPDATE would clear errors
      if (recv_done && busy)                                  r_err <= ERR_OVERRUN;
      else if ((r_state == ST_DECODE) && !w_cmd_ok)           r_err <= ERR_BAD_OP;
      else if ((r_state == ST_WRITE) && !cfg_ready && w_expired) r_err <= ERR_TIMEOUT;
      else if (r_state == ST_UPDATE)                          r_err <= ERR_NONE;
    end
  end

endmodule

// File: tb/tb_dds_cfg_ctrl.sv
// Directed bench for dds_cfg_ctrl: frame decode, handshake timing, errors,
// timeout, overrun, counter wrap and asynchronous reset.
module tb_dds_cfg_ctrl;

  localparam int TO = 1024;

  logic        clk, rst, recv_done, cfg_ready;
  logic [7:0]  dataA, dataD;
  logic [15:0] dataB, dataC;
  logic        cfg_valid, dds_update, busy;
  logic [1:0]  cfg_ch, err_code;
  logic [2:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic [7:0]  cmd_cnt;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_cnt = 8'd0;

  dds_cfg_ctrl #(.TIMEOUT_CYC(TO), .NUM_CH(4)) dut (
    .sys_clk(clk), .sys_rst_n(rst), .recv_done(recv_done),
    .dataA(dataA), .dataB(dataB), .dataC(dataC), .dataD(dataD),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .dds_update(dds_update),
    .busy(busy), .err_code(err_code), .cmd_cnt(cmd_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  // Pulses recv_done for one cycle; returns on the negedge after the capture edge.
  task automatic frame(input logic [7:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [7:0] d);
    @(negedge clk);
    dataA = a; dataB = b; dataC = c; dataD = d; recv_done = 1'b1;
    @(negedge clk);
    recv_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; recv_done = 1'b0; cfg_ready = 1'b0;
    dataA = 8'h00; dataB = 16'h0; dataC = 16'h0; dataD = 8'h00;
    step(); step();
    n_vec++;
    if ({cfg_valid, dds_update, busy, cfg_ch, cfg_addr, cfg_data, err_code, cmd_cnt} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got v%b u%b b%b ch%0d a%0d d%h e%0d n%0d exp all 0",
               cfg_valid, dds_update, busy, cfg_ch, cfg_addr, cfg_data, err_code, cmd_cnt);
    end
    rst = 1'b0;
    step();
    n_vec++;
    if ({cfg_valid, busy, err_code, cmd_cnt} !== '0) begin
      n_err++;
      $display("FAIL post_reset_idle: got v%b b%b e%0d n%0d exp 0", cfg_valid, busy, err_code, cmd_cnt);
    end
  endtask

  task automatic test_freq();
    cfg_ready = 1'b1;
    frame(8'h01, 16'h5678, 16'h1234, 8'h02);
    n_vec++;
    if ({busy, cfg_valid} !== 2'b10) begin
      n_err++; $display("FAIL freq_decode_cycle: got busy%b valid%b exp busy1 valid0", busy, cfg_valid);
    end
    step();
    n_vec++;
    if ({cfg_valid, cfg_ch, cfg_addr, cfg_data} !== {1'b1, 2'd2, 3'd0, 32'h12345678}) begin
      n_err++; $display("FAIL freq_write: got v%b ch%0d a%0d d%h exp v1 ch2 a0 d12345678",
                        cfg_valid, cfg_ch, cfg_addr, cfg_data);
    end
    step();
    n_vec++;
    if ({dds_update, cfg_valid} !== 2'b10) begin
      n_err++; $display("FAIL freq_update: got upd%b valid%b exp upd1 valid0", dds_update, cfg_valid);
    end
    step();
    exp_cnt = exp_cnt + 8'd1;
    n_vec++;
    if ({dds_update, busy, err_code, cmd_cnt} !== {1'b0, 1'b0, 2'd0, exp_cnt}) begin
      n_err++; $display("FAIL freq_done: got upd%b busy%b e%0d n%0d exp upd0 busy0 e0 n%0d",
                        dds_update, busy, err_code, cmd_cnt, exp_cnt);
    end
  endtask

  task automatic run_op(input string nm, input logic [7:0] a, input logic [15:0] b,
                        input logic [7:0] d, input logic [1:0] ech,
                        input logic [2:0] eaddr, input logic [31:0] edata);
    cfg_ready = 1'b1;
    frame(a, b, 16'hFFFF, d);
    step();
    n_vec++;
    if ({cfg_valid, cfg_ch, cfg_addr, cfg_data} !== {1'b1, ech, eaddr, edata}) begin
      n_err++; $display("FAIL %s_write: got v%b ch%0d a%0d d%h exp v1 ch%0d a%0d d%h",
                        nm, cfg_valid, cfg_ch, cfg_addr, cfg_data, ech, eaddr, edata);
    end
    step(); step();
    exp_cnt = exp_cnt + 8'd1;
    n_vec++;
    if (cmd_cnt !== exp_cnt) begin
      n_err++; $display("FAIL %s_count: got %0d exp %0d", nm, cmd_cnt, exp_cnt);
    end
  endtask

  task automatic test_opcodes();
    run_op("phase", 8'h02, 16'hABCD, 8'hF1, 2'd1, 3'd1, 32'h00000BCD);
    run_op("amp",   8'h03, 16'hFFFF, 8'h33, 2'd3, 3'd2, 32'h000003FF);
    run_op("wave",  8'h04, 16'h0000, 8'hA2, 2'd2, 3'd3, 32'h0000000A);
    run_op("run",   8'h05, 16'h00F9, 8'h03, 2'd0, 3'd4, 32'h00000009);
  endtask

  task automatic test_bad_opcode();
    cfg_ready = 1'b1;
    frame(8'h07, 16'h1111, 16'h2222, 8'h01);
    n_vec++;
    if ({busy, cfg_valid} !== 2'b10) begin
      n_err++; $display("FAIL badop_decode: got busy%b valid%b exp busy1 valid0", busy, cfg_valid);
    end
    step();
    n_vec++;
    if ({busy, cfg_valid, err_code, cmd_cnt} !== {1'b0, 1'b0, 2'd1, exp_cnt}) begin
      n_err++; $display("FAIL badop_result: got busy%b v%b e%0d n%0d exp busy0 v0 e1 n%0d",
                        busy, cfg_valid, err_code, cmd_cnt, exp_cnt);
    end
    step(); step();
    n_vec++;
    if ({busy, cfg_valid, err_code} !== {1'b0, 1'b0, 2'd1}) begin
      n_err++; $display("FAIL badop_sticky: got busy%b v%b e%0d exp busy0 v0 e1", busy, cfg_valid, err_code);
    end
  endtask

  task automatic test_timeout();
    cfg_ready = 1'b0;
    frame(8'h02, 16'h0123, 16'h0000, 8'h01);
    step();
    n_vec++;
    if (cfg_valid !== 1'b1) begin
      n_err++; $display("FAIL timeout_first: got valid%b exp 1", cfg_valid);
    end
    repeat (TO - 1) step();
    n_vec++;
    if ({cfg_valid, err_code} !== {1'b1, 2'd1}) begin
      n_err++; $display("FAIL timeout_last_cycle: got valid%b e%0d exp valid1 e1", cfg_valid, err_code);
    end
    step();
    n_vec++;
    if ({cfg_valid, busy, err_code, cmd_cnt} !== {1'b0, 1'b0, 2'd3, exp_cnt}) begin
      n_err++; $display("FAIL timeout_expired: got v%b busy%b e%0d n%0d exp v0 busy0 e3 n%0d",
                        cfg_valid, busy, err_code, cmd_cnt, exp_cnt);
    end
    cfg_ready = 1'b1;
    step(); step(); step();
    n_vec++;
    if ({busy, dds_update, err_code, cmd_cnt} !== {1'b0, 1'b0, 2'd3, exp_cnt}) begin
      n_err++; $display("FAIL ready_in_idle: got busy%b upd%b e%0d n%0d exp busy0 upd0 e3 n%0d",
                        busy, dds_update, err_code, cmd_cnt, exp_cnt);
    end
  endtask

  task automatic test_overrun();
    cfg_ready = 1'b0;
    frame(8'h01, 16'h1111, 16'h2222, 8'h01);
    step(); step();
    frame(8'h03, 16'h0055, 16'h0000, 8'h02);
    n_vec++;
    if ({err_code, cfg_valid, cfg_ch, cfg_addr, cfg_data} !== {2'd2, 1'b1, 2'd1, 3'd0, 32'h22221111}) begin
      n_err++; $display("FAIL overrun_write: got e%0d v%b ch%0d a%0d d%h exp e2 v1 ch1 a0 d22221111",
                        err_code, cfg_valid, cfg_ch, cfg_addr, cfg_data);
    end
    cfg_ready = 1'b1;
    step();
    n_vec++;
    if ({dds_update, cfg_valid, err_code} !== {1'b1, 1'b0, 2'd2}) begin
      n_err++; $display("FAIL overrun_update: got upd%b v%b e%0d exp upd1 v0 e2", dds_update, cfg_valid, err_code);
    end
    step();
    exp_cnt = exp_cnt + 8'd1;
    n_vec++;
    if ({busy, err_code, cmd_cnt} !== {1'b0, 2'd0, exp_cnt}) begin
      n_err++; $display("FAIL overrun_done: got busy%b e%0d n%0d exp busy0 e0 n%0d", busy, err_code, cmd_cnt, exp_cnt);
    end
    step();
    n_vec++;
    if ({busy, cfg_valid} !== 2'b00) begin
      n_err++; $display("FAIL overrun_dropped: got busy%b v%b exp 00", busy, cfg_valid);
    end
  endtask

  task automatic test_back_to_back();
    cfg_ready = 1'b1;
    frame(8'h01, 16'hBEEF, 16'hDEAD, 8'h00);
    step();
    frame(8'h04, 16'h0000, 16'h0000, 8'h51);
    exp_cnt = exp_cnt + 8'd1;
    n_vec++;
    if ({busy, err_code, cmd_cnt, cfg_data} !== {1'b0, 2'd2, exp_cnt, 32'hDEADBEEF}) begin
      n_err++; $display("FAIL update_overrun: got busy%b e%0d n%0d d%h exp busy0 e2 n%0d dDEADBEEF",
                        busy, err_code, cmd_cnt, cfg_data, exp_cnt);
    end
  endtask

  task automatic test_wrap_and_async_reset();
    rst = 1'b1; step(); rst = 1'b0;
    cfg_ready = 1'b1;
    exp_cnt = 8'd0;
    for (int i = 0; i < 255; i++) begin
      frame(8'h03, 16'(i), 16'h0000, 8'h00);
      step(); step(); step();
    end
    n_vec++;
    if (cmd_cnt !== 8'd255) begin
      n_err++; $display("FAIL count_255: got %0d exp 255", cmd_cnt);
    end
    frame(8'h03, 16'h0001, 16'h0000, 8'h00);
    step(); step(); step();
    n_vec++;
    if (cmd_cnt !== 8'd0) begin
      n_err++; $display("FAIL count_wrap: got %0d exp 0", cmd_cnt);
    end
    cfg_ready = 1'b0;
    frame(8'h01, 16'h4444, 16'h3333, 8'h03);
    frame(8'h01, 16'h4444, 16'h3333, 8'h03);
    n_vec++;
    if ({cfg_valid, err_code} !== {1'b1, 2'd2}) begin
      n_err++; $display("FAIL pre_reset_write: got v%b e%0d exp v1 e2", cfg_valid, err_code);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({cfg_valid, dds_update, busy, cfg_ch, cfg_addr, cfg_data, err_code, cmd_cnt} !== '0) begin
      n_err++;
      $display("FAIL async_reset: got v%b u%b b%b ch%0d a%0d d%h e%0d n%0d exp all 0",
               cfg_valid, dds_update, busy, cfg_ch, cfg_addr, cfg_data, err_code, cmd_cnt);
    end
    step(); rst = 1'b0; cfg_ready = 1'b1;
    step(); step(); step();
    n_vec++;
    if ({cfg_valid, busy, dds_update, cmd_cnt} !== '0) begin
      n_err++; $display("FAIL no_replay: got v%b b%b u%b n%0d exp 0", cfg_valid, busy, dds_update, cmd_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_freq();
    test_opcodes();
    test_bad_opcode();
    test_timeout();
    test_overrun();
    test_back_to_back();
    test_wrap_and_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dds_cfg_ctrl.md
DDS_CFG_CTRL -- requirements
Module: dds_cfg_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1024, max cycles WRITE waits for cfg_ready.
REQ-002 Parameter NUM_CH, default 4, number of DDS channels (2-bit channel field).
REQ-003 sys_clk  input  1  single clock; all logic rising-edge.
REQ-004 sys_rst_n  input  1  asynchronous, active-high reset (despite the name).
REQ-005 recv_done  input  1  one-cycle strobe: decoded frame valid on dataA..dataD.
REQ-006 dataA  input  8  opcode.
REQ-007 dataB  input  16  payload low / phase / amplitude / enable mask.
REQ-008 dataC  input  16  payload high (frequency word upper half).
REQ-009 dataD  input  8  [1:0] channel, [7:4] waveform select.
REQ-010 cfg_valid  output  1  DDS config write request.
REQ-011 cfg_ready  input  1  DDS accepts write when cfg_valid & cfg_ready.
REQ-012 cfg_ch  output  2  target channel.
REQ-013 cfg_addr  output  3  register select: 0 FREQ, 1 PHASE, 2 AMP, 3 WAVE, 4 RUN.
REQ-014 cfg_data  output  32  register write data.
REQ-015 dds_update  output  1  one-cycle strobe after each accepted write.
REQ-016 busy  output  1  high in any state except IDLE.
REQ-017 err_code  output  2  0 none, 1 bad opcode, 2 overrun, 3 timeout.
REQ-018 cmd_cnt  output  8  count of successfully applied commands.

Function
REQ-019 Opcode map: 0x01 FREQ data={dataC,dataB}; 0x02 PHASE data={20'b0,dataB[11:0]}; 0x03 AMP data={22'b0,dataB[9:0]}; 0x04 WAVE data={28'b0,dataD[7:4]}; 0x05 RUN data={28'b0,dataB[3:0]}, cfg_ch=0.
REQ-020 States IDLE, DECODE, WRITE, UPDATE; encoding from package.
REQ-021 IDLE: recv_done captures dataA..dataD into a command register, -> DECODE next cycle.
REQ-022 DECODE (one cycle): valid opcode loads cfg_ch/cfg_addr/cfg_data, -> WRITE; invalid opcode sets err_code=1, -> IDLE, no cfg_valid.
REQ-023 WRITE: cfg_valid=1 and cfg_ch/addr/data held stable until handshake; cfg_valid first asserted 2 cycles after recv_done.
REQ-024 Handshake cycle (cfg_valid & cfg_ready) -> UPDATE; cfg_valid drops the following cycle.
REQ-025 UPDATE (one cycle): dds_update=1, cmd_cnt+1 (wraps 255->0), err_code cleared to 0, -> IDLE.
REQ-026 Timeout: WRITE counter counts from 0; reaching TIMEOUT_CYC-1 without handshake sets err_code=3, deasserts cfg_valid, -> IDLE; cmd_cnt unchanged.
REQ-027 recv_done while busy: frame dropped, err_code=2, current command continues unaffected.
REQ-028 recv_done in the same cycle UPDATE->IDLE occurs counts as busy (dropped, overrun).
REQ-029 err_code is sticky until the next successful UPDATE or reset; a later error overwrites an earlier one.
REQ-030 cfg_ready sampled only in WRITE; cfg_ready high in other states is ignored.
REQ-031 dataD[1:0] values >= NUM_CH are treated as bad opcode (err_code=1).

Reset
REQ-032 On reset: state IDLE; cfg_valid, dds_update, busy = 0; cfg_ch, cfg_addr, cfg_data, err_code, cmd_cnt = 0; timeout counter and command register = 0.
REQ-033 Reset asserted mid-WRITE drops cfg_valid immediately (asynchronous); the pending command is discarded, not replayed.

Structure
REQ-034 Package dds_cfg_pkg holds opcode constants, cfg_addr codes, err_code values, and state encoding.
REQ-035 Timeout counter is a separate sub-module dds_cfg_timeout (start/clear in, expired out, parameter TIMEOUT_CYC).

Verification
REQ-036 recv_done, dataA=0x01, dataB=0x5678, dataC=0x1234, dataD=0x02, cfg_ready=1 -> cfg_valid at +2, cfg_addr=0, cfg_ch=2, cfg_data=0x12345678; dds_update at +3; cmd_cnt=1.
REQ-037 dataA=0x07 -> no cfg_valid, err_code=1, busy low after 2 cycles.
REQ-038 PHASE command, cfg_ready held 0 for TIMEOUT_CYC cycles -> cfg_valid drops, err_code=3, cmd_cnt unchanged.
REQ-039 Second recv_done 3 cycles into a stalled WRITE -> err_code=2, first command completes when cfg_ready rises, then err_code=0.
REQ-040 Apply 256 valid commands -> cmd_cnt wraps to 0; reset asserted mid-WRITE -> all outputs 0 same cycle.
